genius_controle_param: RTL and testbench
========================================

Name: genius_controle_param

Overview:
Parametrised control unit for the Genius (Simon) memory game, with its own counters and timers. It plays back a growing sequence from an external pattern memory on the LEDs, then checks the player's button presses against that memory. It supports N buttons, a sequence depth set by parameter, a target length latched at game start, and cycle-count show/gap/timeout intervals. It sits between the board I/O (buttons, LEDs, 7-segment debug) and a one-hot pattern ROM/RAM.

Parameters:
N_BOTOES, 4, number of buttons/LEDs; memory words are one-hot of this width
ADDR_W, 4, memory address width; maximum sequence length is 2**ADDR_W
CNT_W, 16, width of the interval/timeout counter
T_MOSTRA, 1000, cycles an LED stays lit during playback
T_INTERVALO, 500, cycles of dark gap after each shown item and between rounds
T_TIMEOUT, 5000, cycles allowed per player press
N_VIDAS, 3, attempts per game (used only with GENIUS_VIDAS_EN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; returns the FSM to inicial
iniciar  in  1  start / restart request, level-sampled
limite  in  ADDR_W  index of the last round (0-based), latched in preparacao
botoes  in  N_BOTOES  raw button levels (already synchronised)
mem_dado  in  N_BOTOES  memory word at mem_endereco, one-hot
mem_endereco  out  ADDR_W  current sequence position
leds  out  N_BOTOES  LED drive
rodada  out  ADDR_W  current round index
vidas  out  2  remaining attempts
pronto, acertou, errou, fim_timeout  out  1 each  end-of-game flags
db_estado  out  4  state code

Behaviour:
- All outputs are registered or Moore-decoded. After reset: state = inicial, mem_endereco = 0, rodada = 0, timer = 0, leds = 0, all flags = 0, vidas = 0.
- Press detection: `jogada` = (botoes != 0) && (botoes_prev == 0). botoes_prev is updated every cycle. A held button never re-triggers.
- States and codes:
  - inicial 0: iniciar -> preparacao.
  - preparacao 1: clear address, rodada and timer; latch limite; load vidas = N_VIDAS; -> mostra.
  - mostra 9: leds = mem_dado; after T_MOSTRA cycles -> intervalo_mostra.
  - intervalo_mostra A: leds = 0; after T_INTERVALO cycles -> proxima_mostra.
  - proxima_mostra 2: if mem_endereco == rodada -> inicia_sequencia; else increment address -> mostra.
  - inicia_sequencia B: address = 0, timer = 0 -> espera.
  - espera 3: leds = botoes (echo); timer counts up.
    - jogada -> registra. jogada has priority over timeout in the same cycle.
    - Otherwise, timer == T_TIMEOUT-1 -> timeout event.
  - registra 4: capture botoes into jogada_reg -> compara.
  - compara 5:
    - jogada_reg == mem_dado and address < rodada -> proxima_jogada.
    - Equal and address == rodada -> fim_rodada.
    - Otherwise -> error event. A multi-button press always mismatches.
  - proxima_jogada 6: increment address, clear timer -> espera.
  - fim_rodada 7: rodada == limite -> final_acertou; else -> intervalo_rodada.
  - intervalo_rodada C: leds = 0; after T_INTERVALO cycles -> proxima_rodada.
  - proxima_rodada 8: rodada++, address = 0 -> mostra.
  - final_timeout D, final_acertou E, final_errou F: pronto = 1 plus the matching flag. iniciar -> preparacao. Flags drop when preparacao is entered.
- Each interval/timeout count means exactly that many cycles resident in the state. The timer clears on every state entry.
- The address is held stable from espera through compara, so memory with 1-cycle read latency is valid.
- limite = 0 gives a single-item game.
- The address never exceeds rodada, and rodada never exceeds limite, so no wrap occurs.
- iniciar is ignored in all non-final, non-inicial states.
- reset asserted in any state -> inicial on the next edge, with all reset values applied.

Optional Feature:
GENIUS_VIDAS_EN
- Defined: an error or timeout event with vidas > 1 goes to perdeu_vida (code 0). In perdeu_vida: vidas--, address = 0, leds all on for T_INTERVALO cycles, then -> mostra, replaying the same round (rodada unchanged). With vidas == 1 the event goes to final_errou / final_timeout as normal.
- Undefined: no lives logic. Error -> final_errou and timeout -> final_timeout directly. vidas is tied to 0 and code 0 is used only by inicial.

Test Plan:
Bench parameters: T_MOSTRA=4, T_INTERVALO=2, T_TIMEOUT=20, ADDR_W=3, N_BOTOES=4.
- Full win: memory 1,2,4,8; limite=3; correct presses each round -> final_acertou, acertou=1, pronto=1, rodada=3; round 0 shows exactly 4 lit cycles then 2 dark cycles.
- Wrong press: round 1, second press 4'b0100 against expected 4'b0010 -> final_errou, errou=1, mem_endereco=1.
- Timeout: no press for 20 cycles in espera -> final_timeout on the 21st cycle, fim_timeout=1. A press arriving in cycle 20 -> registra instead (priority check).
- Held button and double press: hold 4'b0001 for 50 cycles counts as one press. Press 4'b0011 -> error.
- Reset mid-playback in mostra -> next cycle db_estado=0, leds=0, rodada=0. iniciar restarts cleanly.
- With GENIUS_VIDAS_EN and N_VIDAS=2: first error -> perdeu_vida, vidas=1, same round replayed from address 0. Second error -> final_errou.

Source files
------------

// File: rtl/genius_controle_param.sv
// Genius (Simon) game controller: LED playback from a one-hot pattern memory, then player checking.
// Optional lives/retry support is enabled with `define GENIUS_VIDAS_EN.
module genius_controle_param #(
  parameter int N_BOTOES    = 4,
  parameter int ADDR_W      = 4,
  parameter int CNT_W       = 16,
  parameter int T_MOSTRA    = 1000,
  parameter int T_INTERVALO = 500,
  parameter int T_TIMEOUT   = 5000,
  parameter int N_VIDAS     = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [ADDR_W-1:0]   limite,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [N_BOTOES-1:0] mem_dado,
  output logic [ADDR_W-1:0]   mem_endereco,
  output logic [N_BOTOES-1:0] leds,
  output logic [ADDR_W-1:0]   rodada,
  output logic [1:0]          vidas,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                fim_timeout,
  output logic [3:0]          db_estado
);

`ifdef GENIUS_VIDAS_EN
  localparam bit VIDAS_EN = 1'b1;
`else
  localparam bit VIDAS_EN = 1'b0;
`endif

  localparam logic [1:0]       VIDAS_CARGA   = VIDAS_EN ? 2'(N_VIDAS) : 2'd0;
  localparam logic [CNT_W-1:0] LIM_MOSTRA    = CNT_W'(T_MOSTRA - 1);
  localparam logic [CNT_W-1:0] LIM_INTERVALO = CNT_W'(T_INTERVALO - 1);
  localparam logic [CNT_W-1:0] LIM_TIMEOUT   = CNT_W'(T_TIMEOUT - 1);

  // Low nibble is the debug code; perdeu_vida shares code 0 with inicial via bit 4.
  typedef enum logic [4:0] {
    S_INICIAL          = 5'h00,
    S_PREPARACAO       = 5'h01,
    S_PROXIMA_MOSTRA   = 5'h02,
    S_ESPERA           = 5'h03,
    S_REGISTRA         = 5'h04,
    S_COMPARA          = 5'h05,
    S_PROXIMA_JOGADA   = 5'h06,
    S_FIM_RODADA       = 5'h07,
    S_PROXIMA_RODADA   = 5'h08,
    S_MOSTRA           = 5'h09,
    S_INTERVALO_MOSTRA = 5'h0A,
    S_INICIA_SEQ       = 5'h0B,
    S_INTERVALO_RODADA = 5'h0C,
    S_FINAL_TIMEOUT    = 5'h0D,
    S_FINAL_ACERTOU    = 5'h0E,
    S_FINAL_ERROU      = 5'h0F,
    S_PERDEU_VIDA      = 5'h10
  } estado_t;

  estado_t             r_estado, w_prox;
  logic [CNT_W-1:0]    r_tempo;
  logic [ADDR_W-1:0]   r_endereco, r_rodada, r_limite;
  logic [1:0]          r_vidas;
  logic [N_BOTOES-1:0] r_botoes_ant, r_jogada;
  logic                w_jogada, w_igual, w_perde_vida, w_conta;

  // Rising edge of "any button": a held button never re-triggers.
  assign w_jogada     = (|botoes) && !(|r_botoes_ant);
  assign w_igual      = (r_jogada == mem_dado);
  assign w_perde_vida = VIDAS_EN && (r_vidas > 2'd1);
  assign w_conta      = (r_estado == S_MOSTRA) || (r_estado == S_INTERVALO_MOSTRA) ||
                        (r_estado == S_ESPERA) || (r_estado == S_INTERVALO_RODADA) ||
                        (r_estado == S_PERDEU_VIDA);

  always_ff @(posedge clock) begin
    if (reset) r_estado <= S_INICIAL;
    else       r_estado <= w_prox;
  end

  always_comb begin
    w_prox      = r_estado;
    leds        = '0;
    pronto      = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    fim_timeout = 1'b0;
    case (r_estado)
      S_INICIAL:          if (iniciar) w_prox = S_PREPARACAO;
      S_PREPARACAO:       w_prox = S_MOSTRA;
      S_MOSTRA: begin
        leds = mem_dado;
        if (r_tempo == LIM_MOSTRA) w_prox = S_INTERVALO_MOSTRA;
      end
      S_INTERVALO_MOSTRA: if (r_tempo == LIM_INTERVALO) w_prox = S_PROXIMA_MOSTRA;
      S_PROXIMA_MOSTRA:   w_prox = (r_endereco == r_rodada) ? S_INICIA_SEQ : S_MOSTRA;
      S_INICIA_SEQ:       w_prox = S_ESPERA;
      S_ESPERA: begin
        leds = botoes;
        if (w_jogada)                   w_prox = S_REGISTRA;
        else if (r_tempo == LIM_TIMEOUT) w_prox = w_perde_vida ? S_PERDEU_VIDA : S_FINAL_TIMEOUT;
      end
      S_REGISTRA:         w_prox = S_COMPARA;
      S_COMPARA: begin
        if (!w_igual)                      w_prox = w_perde_vida ? S_PERDEU_VIDA : S_FINAL_ERROU;
        else if (r_endereco == r_rodada)   w_prox = S_FIM_RODADA;
        else                               w_prox = S_PROXIMA_JOGADA;
      end
      S_PROXIMA_JOGADA:   w_prox = S_ESPERA;
      S_FIM_RODADA:       w_prox = (r_rodada == r_limite) ? S_FINAL_ACERTOU : S_INTERVALO_RODADA;
      S_INTERVALO_RODADA: if (r_tempo == LIM_INTERVALO) w_prox = S_PROXIMA_RODADA;
      S_PROXIMA_RODADA:   w_prox = S_MOSTRA;
      S_PERDEU_VIDA: begin
        leds = '1;
        if (r_tempo == LIM_INTERVALO) w_prox = S_MOSTRA;
      end
      S_FINAL_TIMEOUT: begin
        pronto      = 1'b1;
        fim_timeout = 1'b1;
        if (iniciar) w_prox = S_PREPARACAO;
      end
      S_FINAL_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        if (iniciar) w_prox = S_PREPARACAO;
      end
      S_FINAL_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
        if (iniciar) w_prox = S_PREPARACAO;
      end
      default:            w_prox = S_INICIAL;
    endcase
  end

  // Residency timer: zero on every state entry, so a limit of T-1 means T cycles in the state.
  always_ff @(posedge clock) begin
    if (reset)                   r_tempo <= '0;
    else if (w_prox != r_estado) r_tempo <= '0;
    else if (w_conta)            r_tempo <= r_tempo + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_endereco   <= '0;
      r_rodada     <= '0;
      r_limite     <= '0;
      r_vidas      <= '0;
      r_botoes_ant <= '0;
      r_jogada     <= '0;
    end else begin
      r_botoes_ant <= botoes;
      case (r_estado)
        S_PREPARACAO: begin
          r_endereco <= '0;
          r_rodada   <= '0;
          r_limite   <= limite;
          r_vidas    <= VIDAS_CARGA;
        end
        S_PROXIMA_MOSTRA: if (r_endereco != r_rodada) r_endereco <= r_endereco + 1'b1;
        S_INICIA_SEQ:     r_endereco <= '0;
        S_REGISTRA:       r_jogada   <= botoes;
        S_PROXIMA_JOGADA: r_endereco <= r_endereco + 1'b1;
        S_PROXIMA_RODADA: begin
          r_rodada   <= r_rodada + 1'b1;
          r_endereco <= '0;
        end
        default: ;
      endcase
      // Losing a life replays the current round from its first item.
      if ((w_prox == S_PERDEU_VIDA) && (r_estado != S_PERDEU_VIDA)) begin
        r_vidas    <= r_vidas - 2'd1;
        r_endereco <= '0;
      end
    end
  end

  assign mem_endereco = r_endereco;
  assign rodada       = r_rodada;
  assign vidas        = r_vidas;
  assign db_estado    = r_estado[3:0];

endmodule

// File: tb/tb_genius_controle_param.sv
// Bench for genius_controle_param: game table plus hand-written corner sequences, LED playback scoreboard.
module tb_genius_controle_param;
  localparam int NB = 4, AW = 3, TM = 4, TI = 2, TT = 20, NV = 2;
`ifdef GENIUS_VIDAS_EN
  localparam int VIDAS_EXP = NV;
`else
  localparam int VIDAS_EXP = 0;
`endif

  logic          clock = 1'b0;
  logic          reset, iniciar;
  logic [AW-1:0] limite, mem_endereco, rodada;
  logic [NB-1:0] botoes, mem_dado, leds;
  logic [1:0]    vidas;
  logic          pronto, acertou, errou, fim_timeout;
  logic [3:0]    db_estado;
  logic [NB-1:0] mem_arr [8];

  genius_controle_param #(
    .N_BOTOES(NB), .ADDR_W(AW), .CNT_W(16), .T_MOSTRA(TM), .T_INTERVALO(TI),
    .T_TIMEOUT(TT), .N_VIDAS(NV)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .limite(limite), .botoes(botoes),
    .mem_dado(mem_dado), .mem_endereco(mem_endereco), .leds(leds), .rodada(rodada),
    .vidas(vidas), .pronto(pronto), .acertou(acertou), .errou(errou),
    .fim_timeout(fim_timeout), .db_estado(db_estado)
  );

  assign mem_dado = mem_arr[mem_endereco];
  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  logic [NB-1:0] sb [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Playback monitor: each mostra entry pops the expected item; lit/dark lengths are measured.
  logic [3:0]    prev_st = 4'h0;
  int            show_cnt = 0, gap_cnt = 0;
  logic [NB-1:0] cur_exp = '0;
  always @(negedge clock) begin
    if (prev_st == 4'h9 && db_estado == 4'hA) chk("show_len", show_cnt, TM);
    if (prev_st == 4'hA && db_estado == 4'h2) chk("gap_len", gap_cnt, TI);
    if (db_estado == 4'h9) begin
      if (prev_st != 4'h9) begin
        show_cnt = 0;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else cur_exp = sb.pop_front();
      end
      show_cnt++;
      chk("show_leds", leds, cur_exp);
    end
    if (db_estado == 4'hA) begin
      if (prev_st != 4'hA) gap_cnt = 0;
      gap_cnt++;
      chk("gap_leds", leds, 0);
    end
    prev_st = db_estado;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_st(input logic [3:0] s, input int lim, input string nm);
    int k = 0;
    while (db_estado !== s && k < lim) begin tick(); k++; end
    chk(nm, db_estado, s);
  endtask

  task automatic press(input logic [NB-1:0] v);
    botoes = v; tick(); tick(); botoes = '0; tick();
  endtask

  task automatic push_round(input int r);
    for (int i = 0; i <= r; i++) sb.push_back(mem_arr[i]);
  endtask

  task automatic load_mem(input logic [3:0][NB-1:0] w);
    for (int i = 0; i < 8; i++) mem_arr[i] = (i < 4) ? w[i] : '0;
  endtask

  task automatic start_game(input logic [AW-1:0] lim);
    limite = lim; iniciar = 1'b1; push_round(0); tick(); iniciar = 1'b0;
    chk("prep_state", db_estado, 1);
    chk("prep_pronto", pronto, 0);
    tick();
    limite = '1; // from here on only the latched copy may matter
  endtask

  typedef struct {
    string              nm;
    logic [3:0][NB-1:0] words;
    int                 lim, err_r, err_i, to_r, to_i, e_rod, e_adr;
    logic [NB-1:0]      err_v;
    logic [3:0]         e_st;
    bit                 e_ac, e_er, e_to;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [3:0][NB-1:0] w, input int lim,
                              input int er, input int ei, input logic [NB-1:0] ev,
                              input int tr, input int ti, input logic [3:0] st,
                              input int rod, input int adr, input bit ac, input bit ef, input bit tf);
    vec_t v;
    v.nm = nm; v.words = w; v.lim = lim; v.err_r = er; v.err_i = ei; v.err_v = ev;
    v.to_r = tr; v.to_i = ti; v.e_st = st; v.e_rod = rod; v.e_adr = adr;
    v.e_ac = ac; v.e_er = ef; v.e_to = tf;
    return v;
  endfunction

  task automatic run_game(input vec_t v);
    bit stop = 0;
    load_mem(v.words);
    start_game(AW'(v.lim));
    for (int r = 0; r <= v.lim && !stop; r++) begin
      for (int i = 0; i <= r && !stop; i++) begin
        wait_st(4'h3, 200, {v.nm, "_espera"});
        if (r == v.to_r && i == v.to_i) stop = 1;
        else if (r == v.err_r && i == v.err_i) begin press(v.err_v); stop = 1; end
        else press(v.words[i]);
      end
      if (!stop && r < v.lim) begin
        wait_st(4'hC, 20, {v.nm, "_gap"});
        push_round(r + 1);
      end
    end
    wait_st(v.e_st, 300, {v.nm, "_state"});
    chk({v.nm, "_pronto"}, pronto, 1);
    chk({v.nm, "_acertou"}, acertou, v.e_ac);
    chk({v.nm, "_errou"}, errou, v.e_er);
    chk({v.nm, "_timeout"}, fim_timeout, v.e_to);
    chk({v.nm, "_rodada"}, rodada, v.e_rod);
    chk({v.nm, "_addr"}, mem_endereco, v.e_adr);
    chk({v.nm, "_vidas"}, vidas, VIDAS_EXP);
  endtask

  vec_t vecs [$];
  localparam logic [3:0][NB-1:0] W_SEQ = {4'h8, 4'h4, 4'h2, 4'h1};

  initial begin
    vecs.push_back(mk("win",    W_SEQ, 3, -1, -1, '0, -1, -1, 4'hE, 3, 3, 1, 0, 0));
    vecs.push_back(mk("single", {4'h0, 4'h0, 4'h0, 4'h2}, 0, -1, -1, '0, -1, -1, 4'hE, 0, 0, 1, 0, 0));
    vecs.push_back(mk("alt",    {4'h1, 4'h8, 4'h4, 4'h8}, 2, -1, -1, '0, -1, -1, 4'hE, 2, 2, 1, 0, 0));
`ifndef GENIUS_VIDAS_EN
    vecs.push_back(mk("wrong",  W_SEQ, 3, 1, 1, 4'b0100, -1, -1, 4'hF, 1, 1, 0, 1, 0));
    vecs.push_back(mk("tmo",    W_SEQ, 3, -1, -1, '0, 2, 1, 4'hD, 2, 1, 0, 0, 1));
    vecs.push_back(mk("double", W_SEQ, 3, 0, 0, 4'b0011, -1, -1, 4'hF, 0, 0, 0, 1, 0));
`endif

    reset = 1'b1; iniciar = 1'b0; botoes = '0; limite = '0;
    load_mem('0);
    tick(); tick();
    chk("rst_state", db_estado, 0);
    chk("rst_leds", leds, 0);
    chk("rst_rodada", rodada, 0);
    chk("rst_addr", mem_endereco, 0);
    chk("rst_flags", {pronto, acertou, errou, fim_timeout}, 0);
    chk("rst_vidas", vidas, 0);
    reset = 1'b0; tick(); tick();
    chk("idle_state", db_estado, 0);

    // Reset in the middle of round-1 playback
    load_mem(W_SEQ);
    start_game(3);
    wait_st(4'h3, 100, "mid_espera");
    press(4'h1);
    wait_st(4'hC, 20, "mid_gap");
    push_round(1);
    wait_st(4'h9, 20, "mid_mostra");
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_state", db_estado, 0);
    chk("mid_rst_leds", leds, 0);
    chk("mid_rst_rodada", rodada, 0);
    chk("mid_rst_addr", mem_endereco, 0);
    sb.delete();

    foreach (vecs[k]) run_game(vecs[k]);

`ifndef GENIUS_VIDAS_EN
    // Timeout lands on exactly the 21st cycle after espera entry
    load_mem(W_SEQ);
    start_game(0);
    wait_st(4'h3, 100, "to_espera");
    for (int i = 0; i < TT - 1; i++) tick();
    chk("to_cycle20", db_estado, 3);
    tick();
    chk("to_cycle21", db_estado, 4'hD);
    chk("to_flag", fim_timeout, 1);

    // Press in the last allowed cycle wins over timeout
    start_game(0);
    wait_st(4'h3, 100, "prio_espera");
    for (int i = 0; i < TT - 1; i++) tick();
    botoes = 4'h1; tick();
    chk("prio_registra", db_estado, 4);
    tick(); botoes = '0;
    wait_st(4'hE, 5, "prio_final");
    chk("prio_acertou", acertou, 1);

    // Button held for 50 cycles counts once; round 1 then times out
    begin
      bit pushed = 0;
      load_mem({4'h0, 4'h0, 4'h2, 4'h1});
      start_game(1);
      wait_st(4'h3, 100, "hold_espera");
      botoes = 4'h1;
      for (int i = 0; i < 50; i++) begin
        if (db_estado == 4'hC && !pushed) begin push_round(1); pushed = 1; end
        tick();
      end
      botoes = '0;
      wait_st(4'hD, 100, "hold_final");
      chk("hold_rodada", rodada, 1);
      chk("hold_addr", mem_endereco, 0);
    end
`else
    // Lives: first error replays round 1 from address 0, second error ends the game
    load_mem({4'h0, 4'h0, 4'h2, 4'h1});
    start_game(1);
    wait_st(4'h3, 100, "vl_espera0");
    press(4'h1);
    wait_st(4'hC, 20, "vl_gap");
    push_round(1);
    wait_st(4'h3, 100, "vl_espera1");
    press(4'h1);
    wait_st(4'h3, 20, "vl_espera2");
    press(4'h4);
    chk("vl_state", db_estado, 0);
    chk("vl_vidas", vidas, 1);
    chk("vl_leds", leds, 4'hF);
    chk("vl_rodada", rodada, 1);
    chk("vl_addr", mem_endereco, 0);
    push_round(1);
    wait_st(4'h3, 100, "vl_replay");
    chk("vl_replay_addr", mem_endereco, 0);
    press(4'h1);
    wait_st(4'h3, 20, "vl_replay2");
    press(4'h4);
    wait_st(4'hF, 10, "vl_final");
    chk("vl_errou", errou, 1);
    chk("vl_vidas_end", vidas, 1);
    chk("vl_rodada_end", rodada, 1);
`endif

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
